ct_ram_burst_master: RTL and testbench
======================================

// Module: ct_ram_burst_master
// PURPOSE
//  Wishbone B3 master that drives the compute tile RAM from the tile's cache
//  refill/write-back path. Turns one request into a classic single access or a
//  wrapping incrementing burst of LINE_BEATS words, with correct cti/bte/adr
//  sequencing. Streams write data in per beat and returns read data per ack.
// PARAMETERS
//  dw          32  data width (word size), bits
//  aw          32  byte address width
//  LINE_BEATS  4   burst length in words; legal values 4, 8, 16
//  TIMEOUT     255 cycles without ack before abort (CT_RAM_BURST_MASTER_TIMEOUT_EN only)
// PORTS
//  wb_clk_i    in  1      clock
//  wb_rst_i    in  1      synchronous reset, active-low (0 = reset)
//  req_valid_i in  1      request valid
//  req_ready_o out 1      request accepted when valid & ready
//  req_we_i    in  1      1 = write, 0 = read
//  req_burst_i in  1      1 = LINE_BEATS burst, 0 = single classic access
//  req_adr_i   in  aw     byte address; word aligned, bits[1:0] ignored
//  req_sel_i   in  dw/8   byte select; single access only, bursts use all ones
//  wdat_i      in  dw     write data for the current beat
//  wdat_valid_i in 1      write data valid
//  wdat_ready_o out 1     beat consumed (wdat_valid_i & wb_ack_i on a write)
//  rdat_o      out dw     read data (registered wb_dat_i)
//  rdat_valid_o out 1     one-cycle pulse per read beat; no backpressure
//  done_o      out 1      one-cycle pulse after final beat or abort
//  err_o       out 1      one-cycle pulse with done_o if transfer failed
//  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o  out  WB master
//  wb_cti_o    out 3      wb_bte_o  out 2
//  wb_ack_i, wb_err_i, wb_rty_i  in 1;  wb_dat_i  in dw
// BEHAVIOUR
//  Reset: FSM=IDLE; cyc/stb/we/rdat_valid/done/err=0, cti=000, bte=00,
//   adr/dat/sel=0, req_ready_o=0 during reset.
//  FSM IDLE: req_ready_o=1. Accept -> latch we/burst/adr/sel, beat cnt=0,
//   cyc=1 next cycle, go BUS. req_ready_o=0 outside IDLE.
//  BUS: cyc=1. stb=1 for reads; for writes stb=wdat_valid_i. wb_dat_o=wdat_i
//   (combinational). Reads assert no extra stb gap.
//  cti: single=000; burst=010 for beats 0..LINE_BEATS-2, 111 on the last beat.
//  bte: 01/10/11 for LINE_BEATS 4/8/16; 00 for single.
//  Beat accepted = stb & wb_ack_i. Per beat: cnt+1; word addr low log2(LINE_BEATS)
//   bits +1 mod LINE_BEATS; upper bits held (critical-word-first wrap).
//  Read beat: rdat_o<=wb_dat_i, rdat_valid_o=1 the next cycle.
//  Final beat (single, or cnt=LINE_BEATS-1): cyc/stb drop the next cycle;
//   done_o pulses the next cycle; return to IDLE. No new request in the same cycle.
//  wb_err_i while stb: end the transfer immediately; done_o=err_o=1 the next
//   cycle; no further beats. Any remaining write data is not consumed.
//  wb_rty_i: ignored; the RAM drives it 0.
//  Ack without stb: ignored. wb_ack_i & wb_err_i in one cycle: err wins.
//  Reset mid-burst: cyc drops on the reset cycle; no done_o pulse.
// CONFIGURATION
//  CT_RAM_BURST_MASTER_TIMEOUT_EN defined: counter clears on every ack and on
//   every accept, and increments while cyc. At TIMEOUT the transfer aborts:
//   cyc=0, done_o=err_o=1, back to IDLE. Write stalls from wdat_valid_i=0 do
//   not count.
//  Not defined: no counter; the master waits indefinitely for ack.
// TESTING
//  1. Read burst, LINE_BEATS=4, adr=0x18, slave acks every cycle -> wb_adr
//     word 6,7,4,5; cti 010,010,010,111; bte 01; 4 rdat_valid; done_o after 4th ack.
//  2. Single write, adr=0x40, sel=0011 -> cti 000, sel 0011, one beat,
//     wdat_ready_o 1 cycle, done_o=1, err_o=0.
//  3. Write burst, 8 beats, wdat_valid_i low on beats 2 and 5 -> stb drops those
//     cycles; address/cti held; 8 beats written in order; bte 10.
//  4. wb_err_i on beat 2 of a 4-beat read -> cyc=0 next cycle, done_o=err_o=1,
//     2 rdat_valid pulses.
//  5. Reset (wb_rst_i=0) asserted mid-burst -> cyc=0, no done_o pulse;
//     a new request is accepted after reset is released.
//  6. TIMEOUT_EN, TIMEOUT=8, slave never acks -> abort after 8 cycles,
//     done_o=err_o=1.

Source files
------------

// File: rtl/ct_ram_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ct_ram_burst_master_if
// Brief    : Wishbone B3 master-side bus bundle for the compute tile RAM.
// Revision : 1.0
// ============================================================================
interface ct_ram_burst_master_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_rty_i;
    logic [DW-1:0]   wb_dat_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
               wb_cti_o, wb_bte_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
               wb_cti_o, wb_bte_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );
endinterface
`default_nettype wire

// File: rtl/ct_ram_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : ct_ram_burst_master
// Brief    : Wishbone B3 master turning cache refill/write-back requests into
//            single accesses or wrapping LINE_BEATS bursts.
//            Optional ack timeout: define CT_RAM_BURST_MASTER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module ct_ram_burst_master #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int LINE_BEATS = 4
`ifdef CT_RAM_BURST_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 255
`endif
) (
    input  wire logic            wb_clk_i,
    input  wire logic            wb_rst_i,
    input  wire logic            req_valid_i,
    output logic                 req_ready_o,
    input  wire logic            req_we_i,
    input  wire logic            req_burst_i,
    input  wire logic [AW-1:0]   req_adr_i,
    input  wire logic [DW/8-1:0] req_sel_i,
    input  wire logic [DW-1:0]   wdat_i,
    input  wire logic            wdat_valid_i,
    output logic                 wdat_ready_o,
    output logic [DW-1:0]        rdat_o,
    output logic                 rdat_valid_o,
    output logic                 done_o,
    output logic                 err_o,
    ct_ram_burst_master_if.master wb
);

    localparam int                  C_BEAT_W = $clog2(LINE_BEATS);
    localparam logic [C_BEAT_W-1:0] c_last   = C_BEAT_W'(LINE_BEATS - 1);
    localparam logic [1:0]          c_bte    = (LINE_BEATS == 4) ? 2'b01 :
                                               (LINE_BEATS == 8) ? 2'b10 : 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic                r_burst;
    logic [AW-1:0]       r_adr;
    logic [DW/8-1:0]     r_sel;
    logic [C_BEAT_W-1:0] r_cnt;
    logic [DW-1:0]       r_rdat;
    logic                r_rdat_valid;
    logic                r_done;
    logic                r_err;

    logic w_cyc;
    logic w_stb;
    logic w_accept;
    logic w_beat;
    logic w_err_hit;
    logic w_final;
    logic w_timeout;
    logic w_unused;

    // Bus strobes are gated by reset so cyc falls in the very cycle reset is asserted.
    assign w_cyc     = (r_state == ST_BUS) && wb_rst_i;
    assign w_stb     = w_cyc && (!r_we || wdat_valid_i);
    assign w_accept  = (r_state == ST_IDLE) && req_valid_i;
    assign w_err_hit = w_stb && wb.wb_err_i;
    assign w_beat    = w_stb && wb.wb_ack_i && !wb.wb_err_i;
    assign w_final   = w_beat && (!r_burst || (r_cnt == c_last));

`ifdef CT_RAM_BURST_MASTER_TIMEOUT_EN
    localparam int                   C_TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [C_TMO_W-1:0]   c_tmo_last = C_TMO_W'(TIMEOUT - 1);

    logic [C_TMO_W-1:0] r_tmo;

    // Only strobed cycles count, so a write stalled on wdat_valid_i never times out.
    assign w_timeout = w_stb && !wb.wb_ack_i && !wb.wb_err_i && (r_tmo == c_tmo_last);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_tmo <= '0;
        end else if (w_accept || (w_cyc && wb.wb_ack_i)) begin
            r_tmo <= '0;
        end else if (w_stb) begin
            r_tmo <= r_tmo + C_TMO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid_i) w_state_nxt = ST_BUS;
            ST_BUS:  if (w_final || w_err_hit || w_timeout) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_burst      <= 1'b0;
            r_adr        <= '0;
            r_sel        <= '0;
            r_cnt        <= '0;
            r_rdat       <= '0;
            r_rdat_valid <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rdat_valid <= w_beat && !r_we;
            r_done       <= w_final || w_err_hit || w_timeout;
            r_err        <= w_err_hit || w_timeout;
            if (w_accept) begin
                r_we    <= req_we_i;
                r_burst <= req_burst_i;
                r_adr   <= {req_adr_i[AW-1:2], 2'b00};
                r_sel   <= req_burst_i ? '1 : req_sel_i;
                r_cnt   <= '0;
            end else if (w_beat) begin
                r_cnt                  <= r_cnt + C_BEAT_W'(1);
                // Critical-word-first: only the in-line word index advances and wraps.
                r_adr[2 +: C_BEAT_W]   <= r_adr[2 +: C_BEAT_W] + C_BEAT_W'(1);
            end
            if (w_beat && !r_we) begin
                r_rdat <= wb.wb_dat_i;
            end
        end
    end

    assign req_ready_o  = (r_state == ST_IDLE) && wb_rst_i;
    assign wdat_ready_o = w_beat && r_we;
    assign rdat_o       = r_rdat;
    assign rdat_valid_o = r_rdat_valid;
    assign done_o       = r_done;
    assign err_o        = r_err;

    assign wb.wb_cyc_o = w_cyc;
    assign wb.wb_stb_o = w_stb;
    assign wb.wb_we_o  = w_cyc && r_we;
    assign wb.wb_adr_o = w_cyc ? r_adr : '0;
    assign wb.wb_sel_o = w_cyc ? r_sel : '0;
    assign wb.wb_dat_o = w_cyc ? wdat_i : '0;
    assign wb.wb_cti_o = (w_cyc && r_burst) ? ((r_cnt == c_last) ? 3'b111 : 3'b010) : 3'b000;
    assign wb.wb_bte_o = (w_cyc && r_burst) ? c_bte : 2'b00;

    assign w_unused = &{1'b0, req_adr_i[1:0], wb.wb_rty_i};

endmodule
`default_nettype wire

// File: tb/tb_ct_ram_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_ram_burst_master
// Brief    : Directed self-checking bench for ct_ram_burst_master (4- and 8-beat).
// Revision : 1.0
// ============================================================================
module tb_ct_ram_burst_master;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            req_valid, req_valid8, req_we, req_burst;
    logic [AW-1:0]   req_adr;
    logic [DW/8-1:0] req_sel;
    logic [DW-1:0]   wdat;
    logic            wdat_valid;

    logic            req_ready, wdat_ready, rdat_valid, done, err;
    logic [DW-1:0]   rdat;
    logic            req_ready8, wdat_ready8, rdat_valid8, done8, err8;
    logic [DW-1:0]   rdat8;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rv    = 0;
    int n_done  = 0;
    int n_wr8   = 0;
    int base;

    logic [31:0] exp_adr1 [4] = '{32'h18, 32'h1C, 32'h10, 32'h14};
    logic [31:0] exp_adr3 [8] = '{32'h20C, 32'h210, 32'h214, 32'h218,
                                  32'h21C, 32'h200, 32'h204, 32'h208};

    ct_ram_burst_master_if #(.DW(DW), .AW(AW)) bus  ();
    ct_ram_burst_master_if #(.DW(DW), .AW(AW)) bus8 ();

    ct_ram_burst_master #(
        .DW(DW), .AW(AW), .LINE_BEATS(4)
`ifdef CT_RAM_BURST_MASTER_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_burst_i(req_burst), .req_adr_i(req_adr), .req_sel_i(req_sel),
        .wdat_i(wdat), .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready),
        .rdat_o(rdat), .rdat_valid_o(rdat_valid), .done_o(done), .err_o(err),
        .wb(bus)
    );

    ct_ram_burst_master #(.DW(DW), .AW(AW), .LINE_BEATS(8)) u_dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .req_valid_i(req_valid8), .req_ready_o(req_ready8), .req_we_i(req_we),
        .req_burst_i(req_burst), .req_adr_i(req_adr), .req_sel_i(req_sel),
        .wdat_i(wdat), .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready8),
        .rdat_o(rdat8), .rdat_valid_o(rdat_valid8), .done_o(done8), .err_o(err8),
        .wb(bus8)
    );

    always @(posedge clk) begin
        if (rdat_valid)  n_rv++;
        if (done)        n_done++;
        if (wdat_ready8) n_wr8++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_valid8 = 1'b0; req_we = 1'b0;
        req_burst = 1'b0; req_adr = '0; req_sel = '0; wdat = '0; wdat_valid = 1'b0;
        bus.wb_ack_i  = 1'b0; bus.wb_err_i  = 1'b0; bus.wb_rty_i  = 1'b0; bus.wb_dat_i  = '0;
        bus8.wb_ack_i = 1'b0; bus8.wb_err_i = 1'b0; bus8.wb_rty_i = 1'b0; bus8.wb_dat_i = '0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_cyc",   bus.wb_cyc_o, 1'b0);
        check("rst_stb",   bus.wb_stb_o, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        check("rst_cti",   bus.wb_cti_o, 3'b000);
        check("rst_bte",   bus.wb_bte_o, 2'b00);
        check("rst_adr",   bus.wb_adr_o, 32'h0);
        check("rst_done",  done, 1'b0);
        check("rst_rvld",  rdat_valid, 1'b0);
        step();
        rst_n = 1'b1;

        // 1: 4-beat wrapping read from 0x18
        req_valid = 1'b1; req_we = 1'b0; req_burst = 1'b1; req_adr = 32'h18;
        #1 check("t1_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        base = n_rv;
        for (int i = 0; i < 4; i++) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = 32'h1000_0000 + i;
            #1;
            check("t1_stb", bus.wb_stb_o, 1'b1);
            check("t1_adr", bus.wb_adr_o, exp_adr1[i]);
            check("t1_cti", bus.wb_cti_o, (i == 3) ? 3'b111 : 3'b010);
            check("t1_bte", bus.wb_bte_o, 2'b01);
            if (i > 0) begin
                check("t1_rvld", rdat_valid, 1'b1);
                check("t1_rdat", rdat, 32'h1000_0000 + i - 1);
            end
            step();
        end
        bus.wb_ack_i = 1'b0;
        #1;
        check("t1_cyc_end", bus.wb_cyc_o, 1'b0);
        check("t1_done",    done, 1'b1);
        check("t1_err",     err, 1'b0);
        check("t1_rdat3",   rdat, 32'h1000_0003);
        check("t1_rvld3",   rdat_valid, 1'b1);
        step();
        #1;
        check("t1_done_pulse", done, 1'b0);
        check("t1_nrv", n_rv - base, 4);

        // 2: single write to 0x40, sel 0011
        req_valid = 1'b1; req_we = 1'b1; req_burst = 1'b0; req_adr = 32'h40;
        req_sel = 4'b0011; wdat = 32'hCAFE_0001; wdat_valid = 1'b1;
        step();
        req_valid = 1'b0;
        bus.wb_ack_i = 1'b1;
        #1;
        check("t2_stb",   bus.wb_stb_o, 1'b1);
        check("t2_we",    bus.wb_we_o, 1'b1);
        check("t2_cti",   bus.wb_cti_o, 3'b000);
        check("t2_bte",   bus.wb_bte_o, 2'b00);
        check("t2_sel",   bus.wb_sel_o, 4'b0011);
        check("t2_adr",   bus.wb_adr_o, 32'h40);
        check("t2_dat",   bus.wb_dat_o, 32'hCAFE_0001);
        check("t2_wrdy",  wdat_ready, 1'b1);
        step();
        bus.wb_ack_i = 1'b0; wdat_valid = 1'b0;
        #1;
        check("t2_cyc_end", bus.wb_cyc_o, 1'b0);
        check("t2_done",    done, 1'b1);
        check("t2_err",     err, 1'b0);
        check("t2_wrdy0",   wdat_ready, 1'b0);
        step();

        // 3: 8-beat write burst from 0x20C with stalls before beats 2 and 5
        req_valid8 = 1'b1; req_we = 1'b1; req_burst = 1'b1; req_adr = 32'h20C;
        step();
        req_valid8 = 1'b0;
        bus8.wb_ack_i = 1'b1;
        base = n_wr8;
        for (int b = 0; b < 8; b++) begin
            if (b == 2 || b == 5) begin
                wdat_valid = 1'b0;
                #1;
                check("t3_stall_stb",  bus8.wb_stb_o, 1'b0);
                check("t3_stall_adr",  bus8.wb_adr_o, exp_adr3[b]);
                check("t3_stall_cti",  bus8.wb_cti_o, 3'b010);
                check("t3_stall_wrdy", wdat_ready8, 1'b0);
                step();
            end
            wdat_valid = 1'b1;
            wdat = 32'hA000_0000 + b;
            #1;
            check("t3_stb",  bus8.wb_stb_o, 1'b1);
            check("t3_adr",  bus8.wb_adr_o, exp_adr3[b]);
            check("t3_cti",  bus8.wb_cti_o, (b == 7) ? 3'b111 : 3'b010);
            check("t3_bte",  bus8.wb_bte_o, 2'b10);
            check("t3_sel",  bus8.wb_sel_o, 4'b1111);
            check("t3_dat",  bus8.wb_dat_o, 32'hA000_0000 + b);
            check("t3_wrdy", wdat_ready8, 1'b1);
            step();
        end
        wdat_valid = 1'b0; bus8.wb_ack_i = 1'b0;
        #1;
        check("t3_cyc_end", bus8.wb_cyc_o, 1'b0);
        check("t3_done",    done8, 1'b1);
        check("t3_err",     err8, 1'b0);
        check("t3_nbeats",  n_wr8 - base, 8);
        step();

        // 4: error (with simultaneous ack) on beat 2 of a 4-beat read
        req_valid = 1'b1; req_we = 1'b0; req_burst = 1'b1; req_adr = 32'h0;
        step();
        req_valid = 1'b0;
        base = n_rv;
        for (int i = 0; i < 2; i++) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = 32'h2000_0000 + i;
            step();
        end
        bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1; bus.wb_dat_i = 32'h2000_0002;
        #1 check("t4_stb", bus.wb_stb_o, 1'b1);
        step();
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
        #1;
        check("t4_cyc_end", bus.wb_cyc_o, 1'b0);
        check("t4_done",    done, 1'b1);
        check("t4_err",     err, 1'b1);
        check("t4_rvld",    rdat_valid, 1'b0);
        check("t4_rdat",    rdat, 32'h2000_0001);
        step();
        check("t4_nrv", n_rv - base, 2);

        // 5: reset in the middle of a burst, then a fresh single read
        req_valid = 1'b1; req_we = 1'b0; req_burst = 1'b1; req_adr = 32'h30;
        step();
        req_valid = 1'b0;
        base = n_done;
        bus.wb_ack_i = 1'b1;
        step();
        step();
        rst_n = 1'b0; bus.wb_ack_i = 1'b0;
        #1;
        check("t5_rst_cyc",   bus.wb_cyc_o, 1'b0);
        check("t5_rst_ready", req_ready, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        check("t5_post_cyc",  bus.wb_cyc_o, 1'b0);
        check("t5_post_done", done, 1'b0);
        req_valid = 1'b1; req_burst = 1'b0; req_adr = 32'h44; req_sel = 4'b1111;
        #1 check("t5_ready", req_ready, 1'b1);
        step();
        check("t5_ndone", n_done - base, 0);
        req_valid = 1'b0;
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h5555_AAAA;
        #1;
        check("t5_cyc", bus.wb_cyc_o, 1'b1);
        check("t5_adr", bus.wb_adr_o, 32'h44);
        check("t5_cti", bus.wb_cti_o, 3'b000);
        step();
        bus.wb_ack_i = 1'b0;
        #1;
        check("t5_done", done, 1'b1);
        check("t5_rvld", rdat_valid, 1'b1);
        check("t5_rdat", rdat, 32'h5555_AAAA);
        step();

`ifdef CT_RAM_BURST_MASTER_TIMEOUT_EN
        // 6: slave never acks; abort after 8 strobed cycles
        req_valid = 1'b1; req_we = 1'b0; req_burst = 1'b0; req_adr = 32'h80;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t6_wait_cyc",  bus.wb_cyc_o, 1'b1);
            check("t6_wait_done", done, 1'b0);
            step();
        end
        #1;
        check("t6_cyc_end", bus.wb_cyc_o, 1'b0);
        check("t6_done",    done, 1'b1);
        check("t6_err",     err, 1'b1);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
